// File: rtl/ir_pkg.sv
// Shared widths and helpers for the instruction-register prefetch queue.
// Provides default field widths, pointer sizing and field extraction.
package ir_pkg;

  localparam int IR_DATA_W    = 18;
  localparam int IR_OPCODE_W  = 6;
  localparam int IR_OPERAND_W = 12;
  localparam int IR_WORD_MAX  = 64;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [IR_WORD_MAX-1:0] field_at(
    input logic [IR_WORD_MAX-1:0] w,
    input int                     lsb
  );
    return w >> lsb;
  endfunction

endpackage

// File: rtl/ir_fifo_mem.sv
// DEPTH x DATA_W register-array storage, one write port, async read.
// Ports: clk, i_we/i_waddr/i_wdata, i_raddr/o_rdata (+ i_raddr_b/o_rdata_b with IR_PEEK_EN).
module ir_fifo_mem #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4,
  parameter int PW     = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
`ifdef IR_PEEK_EN
  ,
  input  logic [PW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef IR_PEEK_EN
  assign o_rdata_b = r_mem[i_raddr_b];
`endif

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register with a DEPTH-entry prefetch queue; head split
// into opcode (instruction) and operand (dataout). Registered outputs.
// Ports: clk, rst_n, flush, write_en, datain, load_ready, issue,
// out_valid, dataout, instruction, count.
// Macro IR_PEEK_EN adds next_valid/next_instruction lookahead.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int DATA_W    = IR_DATA_W,
  parameter int OPCODE_W  = IR_OPCODE_W,
  parameter int OPERAND_W = IR_OPERAND_W,
  parameter int DEPTH     = 4,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 write_en,
  input  logic [DATA_W-1:0]    datain,
  output logic                 load_ready,
  input  logic                 issue,
  output logic                 out_valid,
  output logic [OPERAND_W-1:0] dataout,
  output logic [OPCODE_W-1:0]  instruction,
  output logic [CW-1:0]        count
`ifdef IR_PEEK_EN
  ,
  output logic                 next_valid,
  output logic [OPCODE_W-1:0]  next_instruction
`endif
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_out_valid;
  logic [OPERAND_W-1:0] r_dataout;
  logic [OPCODE_W-1:0]  r_instr;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [PW-1:0]        w_rd_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CW-1:0]        w_left;
  logic [DATA_W-1:0]    w_rd_word;
  logic [DATA_W-1:0]    w_head_word;
  logic [OPERAND_W-1:0] w_opnd_nxt;
  logic [OPCODE_W-1:0]  w_op_nxt;

  assign w_full     = (r_count == CW'(DEPTH));
  assign load_ready = !w_full;

  assign w_push = write_en && !w_full && !flush;
  assign w_pop  = issue && r_out_valid && !flush;

  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // Older entries still queued once this cycle's pop is taken.
  assign w_left    = r_count - CW'(w_pop);

  // New head is the word being written now when nothing older remains.
  assign w_head_word = (w_push && w_left == '0) ? datain : w_rd_word;

  assign w_opnd_nxt = OPERAND_W'(field_at(IR_WORD_MAX'(w_head_word), 0));
  assign w_op_nxt   = OPCODE_W'(field_at(IR_WORD_MAX'(w_head_word), OPERAND_W));

`ifdef IR_PEEK_EN
  logic                r_next_valid;
  logic [OPCODE_W-1:0] r_next_instr;
  logic [PW-1:0]       w_nx_addr;
  logic [DATA_W-1:0]   w_nx_rd;
  logic [DATA_W-1:0]   w_nx_word;
  logic [OPCODE_W-1:0] w_nx_op;

  assign w_nx_addr = w_rd_nxt + PW'(1);
  // Entry behind the head is the incoming word when exactly one older remains.
  assign w_nx_word = (w_push && w_left == CW'(1)) ? datain : w_nx_rd;
  assign w_nx_op   = OPCODE_W'(field_at(IR_WORD_MAX'(w_nx_word), OPERAND_W));
`endif

  ir_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_push),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (datain),
    .i_raddr   (w_rd_nxt),
    .o_rdata   (w_rd_word)
`ifdef IR_PEEK_EN
    ,
    .i_raddr_b (w_nx_addr),
    .o_rdata_b (w_nx_rd)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_dataout   <= '0;
      r_instr     <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PW'(w_push);
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        r_dataout <= w_opnd_nxt;
        r_instr   <= w_op_nxt;
      end
    end
  end

`ifdef IR_PEEK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_valid <= 1'b0;
      r_next_instr <= '0;
    end else if (flush) begin
      r_next_valid <= 1'b0;
    end else begin
      r_next_valid <= (w_cnt_nxt >= CW'(2));
      if (w_cnt_nxt >= CW'(2)) r_next_instr <= w_nx_op;
    end
  end

  assign next_valid       = r_next_valid;
  assign next_instruction = r_next_instr;
`endif

  assign out_valid   = r_out_valid;
  assign dataout     = r_dataout;
  assign instruction = r_instr;
  assign count       = r_count;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Self-checking bench for ir_prefetch_queue against a queue-based model.
// Directed scenarios plus a randomized run.
module tb_ir_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        write_en = 1'b0;
  logic [17:0] datain = '0;
  logic        load_ready;
  logic        issue = 1'b0;
  logic        out_valid;
  logic [11:0] dataout;
  logic [5:0]  instruction;
  logic [2:0]  count;
`ifdef IR_PEEK_EN
  logic        next_valid;
  logic [5:0]  next_instruction;
`endif

  int checks = 0;
  int errors = 0;

  logic [17:0] mq[$];
  logic        m_valid = 1'b0;
  logic [11:0] m_data = '0;
  logic [5:0]  m_instr = '0;
  logic        m_nv = 1'b0;
  logic [5:0]  m_ni = '0;

  ir_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .write_en         (write_en),
    .datain           (datain),
    .load_ready       (load_ready),
    .issue            (issue),
    .out_valid        (out_valid),
    .dataout          (dataout),
    .instruction      (instruction),
    .count            (count)
`ifdef IR_PEEK_EN
    ,
    .next_valid       (next_valid),
    .next_instruction (next_instruction)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_data = '0; m_instr = '0;
    m_nv = 0; m_ni = '0;
  endtask

  // One clock: drive at negedge, sample 1 after posedge, advance model.
  task automatic step(input logic we, input logic [17:0] d,
                      input logic iss, input logic fl);
    bit pu, po;
    @(negedge clk);
    write_en = we; datain = d; issue = iss; flush = fl;
    pu = we && (mq.size() < DEPTH) && !fl;
    po = iss && (mq.size() > 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(d);
    end
    m_valid = (mq.size() > 0);
    if (m_valid) begin
      m_data  = mq[0][11:0];
      m_instr = mq[0][17:12];
    end
    m_nv = (mq.size() >= 2);
    if (m_nv) m_ni = mq[1][17:12];
    write_en = 0; issue = 0; flush = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid, count, dataout, instruction, load_ready} !==
        {1'b0, 3'd0, 12'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset: valid=%b cnt=%0d d=%h i=%h lr=%b want 0 0 0 0 1",
               out_valid, count, dataout, instruction, load_ready);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_first_push();
    step(1, 18'h2A5C3, 0, 0);
    checks++;
    if ({out_valid, instruction, dataout, count} !==
        {1'b1, 6'h2A, 12'h5C3, 3'd1}) begin
      errors++;
      $display("FAIL first_push: v=%b i=%h d=%h c=%0d want 1 2a 5c3 1",
               out_valid, instruction, dataout, count);
    end
    step(0, 0, 1, 0);
    checks++;
    if ({out_valid, dataout, count} !== {1'b0, 12'h5C3, 3'd0}) begin
      errors++;
      $display("FAIL empty_hold: v=%b d=%h c=%0d want 0 5c3 0",
               out_valid, dataout, count);
    end
    step(0, 0, 1, 0);
    checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL issue_empty: v=%b c=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    logic [17:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = 18'($urandom);
      step(1, w[i], 0, 0);
    end
    checks++;
    if ({load_ready, count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL full: lr=%b c=%0d want 0 4", load_ready, count);
    end
    step(1, 18'h3FFFF, 0, 0);
    checks++;
    if ({count, dataout, instruction} !== {3'd4, w[0][11:0], w[0][17:12]}) begin
      errors++;
      $display("FAIL drop5th: c=%0d d=%h i=%h want 4 %h %h",
               count, dataout, instruction, w[0][11:0], w[0][17:12]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if ({out_valid, dataout, instruction} !==
          {1'b1, w[i+1][11:0], w[i+1][17:12]}) begin
        errors++;
        $display("FAIL drain%0d: v=%b d=%h i=%h want 1 %h %h", i,
                 out_valid, dataout, instruction, w[i+1][11:0], w[i+1][17:12]);
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if ({out_valid, dataout, count, load_ready} !==
        {1'b0, w[3][11:0], 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL drained: v=%b d=%h c=%0d lr=%b want 0 %h 0 1",
               out_valid, dataout, count, load_ready, w[3][11:0]);
    end
  endtask

  task automatic test_push_pop_one();
    logic [17:0] a, b;
    a = 18'($urandom);
    b = 18'($urandom);
    step(1, a, 0, 0);
    step(1, b, 1, 0);
    checks++;
    if ({out_valid, count, dataout, instruction} !==
        {1'b1, 3'd1, b[11:0], b[17:12]}) begin
      errors++;
      $display("FAIL push_pop1: v=%b c=%0d d=%h i=%h want 1 1 %h %h",
               out_valid, count, dataout, instruction, b[11:0], b[17:12]);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_flush();
    logic [11:0] held;
    for (int i = 0; i < 3; i++) step(1, 18'($urandom), 0, 0);
    held = m_data;
    step(1, 18'h15A5A, 1, 1);
    checks++;
    if ({count, out_valid, load_ready, dataout} !==
        {3'd0, 1'b0, 1'b1, held}) begin
      errors++;
      $display("FAIL flush: c=%0d v=%b lr=%b d=%h want 0 0 1 %h",
               count, out_valid, load_ready, dataout, held);
    end
`ifdef IR_PEEK_EN
    checks++;
    if (next_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_peek: nv=%b want 0", next_valid);
    end
`endif
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if ({count, out_valid} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL flush_absent%0d: c=%0d v=%b want 0 0",
                 i, count, out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, 18'($urandom),
           $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0);
      checks++;
      if ({count, out_valid, load_ready} !==
          {3'(mq.size()), m_valid, 1'(mq.size() < DEPTH)}) begin
        errors++;
        $display("FAIL rnd_ctl%0d: c=%0d v=%b lr=%b want %0d %b %b", n,
                 count, out_valid, load_ready, mq.size(), m_valid,
                 mq.size() < DEPTH);
      end
      checks++;
      if ({dataout, instruction} !== {m_data, m_instr}) begin
        errors++;
        $display("FAIL rnd_head%0d: d=%h i=%h want %h %h", n,
                 dataout, instruction, m_data, m_instr);
      end
`ifdef IR_PEEK_EN
      checks++;
      if ({next_valid, next_instruction} !== {m_nv, m_ni}) begin
        errors++;
        $display("FAIL rnd_peek%0d: nv=%b ni=%h want %b %h", n,
                 next_valid, next_instruction, m_nv, m_ni);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1);
    step(1, 18'($urandom), 0, 0);
    step(1, 18'($urandom), 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({count, out_valid, dataout, instruction, load_ready} !==
        {3'd0, 1'b0, 12'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst: c=%0d v=%b d=%h i=%h lr=%b want 0 0 0 0 1",
               count, out_valid, dataout, instruction, load_ready);
    end
`ifdef IR_PEEK_EN
    checks++;
    if (next_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_peek: nv=%b want 0", next_valid);
    end
`endif
    @(negedge clk);
    rst_n = 1;
    model_reset();
    step(1, 18'h0ABCD, 0, 0);
    checks++;
    if ({out_valid, dataout, instruction, count} !==
        {1'b1, 12'hBCD, 6'h0A, 3'd1}) begin
      errors++;
      $display("FAIL post_rst: v=%b d=%h i=%h c=%0d want 1 bcd 0a 1",
               out_valid, dataout, instruction, count);
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_drain();
    test_push_pop_one();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised instruction register with a small prefetch queue, the successor to the single-entry instruction register. It buffers up to DEPTH fetched instruction words from memory and splits the head word into an opcode field and an operand/address field. The controller consumes instructions in order with `issue`. It sits between the memory data bus and the control unit: the operand drives the bus toward AR/PC, and the opcode drives decode.

Parameters:
DATA_W, 18, width of a fetched instruction word; must be >= OPCODE_W + OPERAND_W
OPCODE_W, 6, opcode field width
OPERAND_W, 12, operand/address field width (low bits of word)
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all queued words (branch/jump taken)
write_en  in  1  push datain this cycle (valid)
datain  in  DATA_W  fetched instruction word
load_ready  out  1  queue can accept a push (= not full)
issue  in  1  pop head entry
out_valid  out  1  head entry valid
dataout  out  OPERAND_W  operand of head, datain[OPERAND_W-1:0]
instruction  out  OPCODE_W  opcode of head, datain[OPERAND_W+OPCODE_W-1:OPERAND_W]
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async assert, sync-safe release): wr/rd pointers 0, count 0, out_valid 0, dataout 0, instruction 0, load_ready 1.
- Push accepted when write_en && load_ready. Bits of datain above OPERAND_W+OPCODE_W are ignored.
- Pop accepted when issue && out_valid. Issue while empty is ignored and does not change count.
- Outputs are registered. A word pushed into an empty queue appears on dataout/instruction with out_valid=1 on the next rising edge (1-cycle latency).
- After a pop, the next entry (if any) appears on the following edge with no bubble. If the queue becomes empty, out_valid goes 0 and dataout/instruction hold the last value.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed when full? No. load_ready = !full only, with no combinational path from issue.
  - When count==1, the pushed word becomes the new head on the next edge.
- Flush has priority over push and pop in the same cycle. Pointers and count go to 0, out_valid goes 0, and the push in that cycle is dropped. dataout/instruction hold their value.
- Pointers wrap modulo DEPTH. count saturates nowhere; it is bounded by the full/empty logic.
- Reset asserted mid-operation clears immediately regardless of clk.

Optional Feature:
IR_PEEK_EN
- Defined: adds outputs next_valid (1) and next_instruction (OPCODE_W), giving the opcode of the entry behind the head, for decode lookahead.
  - Registered, with the same update timing as the head.
  - next_valid = (count >= 2). Cleared by reset and flush.
  - next_instruction holds its value when next_valid is 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package ir_pkg:
  - default width constants (DATA_W, OPCODE_W, OPERAND_W)
  - pointer/count width helper
  - function extracting opcode/operand fields from a word
- One sub-module: ir_fifo_mem, a DEPTH x DATA_W register-array storage with a write port and an async read port.
- Pointer, count and output-register control stay in the top module.

Test Plan:
- Reset then push 18'h2A5C3 (one cycle) -> next edge: out_valid=1, instruction=6'h2A, dataout=12'h5C3, count=1.
- Push 4 words with no issue -> load_ready=0 after the 4th. A 5th write_en is dropped, count stays 4, and the head is still the 1st word.
- Full queue, issue held 4 cycles -> words appear in order, one per cycle. Then out_valid=0, dataout holds the 4th word's operand, count=0.
- count=1, write_en and issue in the same cycle -> next edge: head is the new word, count=1, out_valid=1.
- count=3, flush together with write_en and issue -> next edge: count=0, out_valid=0, load_ready=1. The pushed word is absent on subsequent issues.
- rst_n pulsed low between clock edges with count=2 -> outputs and count are 0 immediately, before the next clk edge. With IR_PEEK_EN, next_valid=0.
